// File: rtl/fifo_reader.sv
// Burst reader: pops burst_len words from a synchronous FIFO and replays them on a
// valid/ready stream through a 2-entry skid buffer, tagging the final word with m_last.
module fifo_reader #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       burst_len,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data_out,
    output logic             fifo_read_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic [7:0]       words_out
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    localparam logic [2:0] Depth = 3'(BUF_DEPTH);

    state_e           state_q, state_d;
    logic [7:0]       len_q;
    logic [7:0]       issued_q;
    logic [7:0]       words_q;
    logic             inflight_q;
    logic [WIDTH-1:0] buf_q [BUF_DEPTH];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q;

    logic             launch, push, pop;
    logic [2:0]       occ_eff;

    assign launch = (state_q == StIdle) && start;
    assign push   = inflight_q;
    assign pop    = m_valid && m_ready;

    // Occupancy counts the head leaving this cycle, so a full pipeline sustains one word/cycle.
    assign occ_eff = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        fifo_read_en = 1'b0;
        if ((state_q == StRun) && !fifo_empty && (issued_q < len_q) && (occ_eff < Depth)) begin
            fifo_read_en = 1'b1;
        end
    end

    assign m_valid   = (count_q != 2'd0);
    assign m_data    = m_valid ? buf_q[rd_ptr_q] : '0;
    assign m_last    = m_valid && (words_q == (len_q - 8'd1));
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign words_out = words_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (burst_len == 8'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (fifo_read_en && (issued_q == (len_q - 8'd1))) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (pop && m_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            len_q      <= 8'd0;
            issued_q   <= 8'd0;
            words_q    <= 8'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_read_en;
            if (launch) begin
                len_q    <= burst_len;
                issued_q <= 8'd0;
                words_q  <= 8'd0;
            end else begin
                if (fifo_read_en) begin
                    issued_q <= issued_q + 8'd1;
                end
                if (pop) begin
                    words_q <= words_q + 8'd1;
                end
            end
            if (push) begin
                buf_q[wr_ptr_q] <= fifo_data_out;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: emulated synchronous FIFO, stream scoreboard checked every
// cycle, and directed bursts with hand-computed expectations.
module tb_fifo_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  burst_len = 8'd0;
    logic        fifo_empty;
    logic [15:0] fifo_data_out = 16'd0;
    logic        fifo_read_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic        busy;
    logic        done;
    logic [7:0]  words_out;

    fifo_reader #(.WIDTH(16), .BUF_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .burst_len    (burst_len),
        .fifo_empty   (fifo_empty),
        .fifo_data_out(fifo_data_out),
        .fifo_read_en (fifo_read_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .busy         (busy),
        .done         (done),
        .words_out    (words_out)
    );

    always #5 clk = ~clk;

    // Emulated FIFO contents
    logic [15:0] mem [64];
    int          rd_idx = 0;
    int          wr_idx = 0;
    logic        force_empty = 1'b0;
    assign fifo_empty = force_empty || (rd_idx == wr_idx);

    int tests = 0;
    int fails = 0;

    // Model state: phase 0 idle, 1 active burst, 2 done cycle
    int          phase = 0;
    int          len = 0;
    int          hs = 0;
    int          acc = 0;
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int          hs_samples [$];
    int          sample_n = 0;
    int          start_sample = 0;
    int          done_sample = 0;
    int          done_cnt = 0;
    int          rd_en_cnt = 0;
    int          hold_cnt = 0;
    int          max_out = 0;
    logic        hold_prev = 1'b0;
    logic [15:0] prev_data = 16'd0;
    logic        prev_last = 1'b0;
    logic        acc_now, hs_now;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Compare process: sample 1 ns before each rising edge, then apply the FIFO pop after it.
    always begin
        @(negedge clk);
        #4;
        sample_n++;
        acc_now = 1'b0;
        hs_now  = 1'b0;
        if (!rst) begin
            chk("rst_read_en", fifo_read_en, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_last", m_last, 0);
            chk("rst_data", m_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_words", words_out, 0);
            phase = 0;
            hs = 0;
            acc = 0;
            exp_q.delete();
            hold_prev = 1'b0;
            rd_idx = wr_idx;
        end else begin
            hs_now  = m_valid && m_ready;
            acc_now = fifo_read_en && !fifo_empty;
            chk("busy", busy, phase != 0);
            chk("done", done, phase == 2);
            chk("words_out", words_out, hs);
            if (phase != 1) chk("valid_outside_burst", m_valid, 0);
            if (fifo_read_en) begin
                chk("read_when_empty", fifo_empty, 0);
                chk("read_beyond_burst", (phase == 1) && (acc < len), 1);
                rd_en_cnt++;
            end
            if (m_valid) chk("last_flag", m_last, hs == len - 1);
            if (hold_prev) begin
                hold_cnt++;
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (hs_now) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_word", m_data, 32'hdead_beef);
                end else begin
                    chk("stream_data", m_data, exp_q.pop_front());
                end
                got_q.push_back(m_data);
                hs_samples.push_back(sample_n);
            end
            if (done) begin
                done_cnt++;
                done_sample = sample_n;
            end
            if (acc_now) begin
                exp_q.push_back(mem[rd_idx]);
                acc++;
            end
            if (hs_now) hs++;
            if (acc - hs > max_out) max_out = acc - hs;
            if (phase == 0 && start) begin
                len = int'(burst_len);
                hs = 0;
                acc = 0;
                start_sample = sample_n;
                phase = (len == 0) ? 2 : 1;
            end else if (phase == 1 && hs_now && hs == len) begin
                phase = 2;
            end else if (phase == 2) begin
                phase = 0;
            end
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end
        @(posedge clk);
        #1;
        if (acc_now) begin
            fifo_data_out = mem[rd_idx];
            rd_idx++;
        end
    end

    task automatic load(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_idx] = first + 16'(i);
            wr_idx++;
        end
    endtask

    task automatic pulse_start(input logic [7:0] l);
        @(negedge clk);
        start = 1'b1;
        burst_len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int db, input int bound);
        int n = 0;
        while (done_cnt == db && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done_seen"}, done_cnt > db, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_range(input string name, input int gb, input logic [15:0] first,
                               input int n);
        chk({name, "_count"}, got_q.size() - gb, n);
        for (int i = 0; i < n; i++) begin
            if (gb + i < got_q.size()) chk({name, "_word"}, got_q[gb + i], first + 16'(i));
        end
    endtask

    initial begin
        int gb, db, rb, hb, gq, n;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_words", words_out, 0);

        // Back-to-back burst of five
        load(16'h0001, 5);
        gb = got_q.size(); db = done_cnt; rb = rd_en_cnt;
        pulse_start(8'd5);
        wait_done("b5", db, 40);
        check_range("b5", gb, 16'h0001, 5);
        if (got_q.size() >= gb + 5) begin
            chk("b5_latency", hs_samples[gb] - start_sample, 3);
            chk("b5_consecutive", hs_samples[gb + 4] - hs_samples[gb], 4);
        end
        chk("b5_done_at", done_sample - start_sample, 8);
        chk("b5_done_cnt", done_cnt - db, 1);
        chk("b5_words", words_out, 5);
        chk("b5_reads", rd_en_cnt - rb, 5);

        // Toggling ready
        load(16'h0010, 4);
        gb = got_q.size(); db = done_cnt; hb = hold_cnt;
        pulse_start(8'd4);
        n = 0;
        while (done_cnt == db && n < 80) begin
            @(negedge clk);
            m_ready = ~m_ready;
            n++;
        end
        m_ready = 1'b1;
        chk("b4_done_seen", done_cnt > db, 1);
        repeat (3) @(negedge clk);
        check_range("b4", gb, 16'h0010, 4);
        chk("b4_stalled", hold_cnt > hb, 1);
        chk("b4_outstanding", max_out <= 2, 1);
        chk("b4_done_cnt", done_cnt - db, 1);
        chk("b4_words", words_out, 4);

        // Underrun gap after the second word
        load(16'h0020, 6);
        gb = got_q.size(); db = done_cnt; rb = rd_en_cnt;
        pulse_start(8'd6);
        n = 0;
        while (got_q.size() < gb + 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b6_second_word", got_q.size() >= gb + 2, 1);
        force_empty = 1'b1;
        repeat (3) @(negedge clk);
        force_empty = 1'b0;
        wait_done("b6", db, 40);
        check_range("b6", gb, 16'h0020, 6);
        chk("b6_reads", rd_en_cnt - rb, 6);
        chk("b6_words", words_out, 6);

        // Zero-length burst with data waiting in the FIFO
        load(16'h0030, 8);
        gb = got_q.size(); db = done_cnt; rb = rd_en_cnt;
        pulse_start(8'd0);
        wait_done("b0", db, 10);
        chk("b0_done_at", done_sample - start_sample, 1);
        chk("b0_reads", rd_en_cnt - rb, 0);
        chk("b0_count", got_q.size() - gb, 0);
        chk("b0_words", words_out, 0);

        // Reset mid-burst, then a fresh burst
        gb = got_q.size();
        pulse_start(8'd8);
        n = 0;
        while (got_q.size() < gb + 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b8_three_words", got_q.size() >= gb + 3, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        gq = got_q.size();
        repeat (3) @(negedge clk);
        load(16'hAAAA, 1);
        load(16'hBBBB, 1);
        repeat (3) @(negedge clk);
        chk("b8_quiet", got_q.size() - gq, 0);
        gb = got_q.size(); db = done_cnt;
        pulse_start(8'd2);
        wait_done("b2", db, 20);
        chk("b2_count", got_q.size() - gb, 2);
        if (got_q.size() >= gb + 2) begin
            chk("b2_first", got_q[gb], 16'hAAAA);
            chk("b2_second", got_q[gb + 1], 16'hBBBB);
        end
        chk("b2_words", words_out, 2);

        // Second start while busy is ignored
        load(16'h0040, 4);
        gb = got_q.size(); db = done_cnt;
        pulse_start(8'd4);
        @(negedge clk);
        start = 1'b1;
        burst_len = 8'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done("b4r", db, 40);
        repeat (5) @(negedge clk);
        check_range("b4r", gb, 16'h0040, 4);
        chk("b4r_done_cnt", done_cnt - db, 1);
        chk("b4r_words", words_out, 4);
        chk("b4r_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
